// File: rtl/epp_regfile.sv
// epp_regfile: EPP slave register file with command strobes, busy/status read-back and EppWait handshake.
// Define EPP_AUTOINC_EN to make every data cycle post-increment the address.
module epp_regfile #(
  parameter int NUM_REGS = 12,
  parameter int NUM_CMDS = 2,
  parameter logic [7:0] STATUS_ADDR = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  EppAstb,
  input  logic                  EppDstb,
  input  logic                  EppWR,
  output logic                  EppWait,
  inout  wire  [7:0]            EppDB,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic [NUM_CMDS-1:0]   cmd_strobe,
  input  logic [NUM_CMDS-1:0]   busy
);
  typedef enum logic [1:0] {IDLE, ACT, ACK} state_t;
  state_t state, state_next;
  logic [1:0] astb_sync, dstb_sync, wr_sync;
  logic is_addr, is_rd, in_cmds, strobe_done;
  logic [7:0] addr, dout, cmd_idx, rd_byte, status, rd_sel;
  logic [7:0] regs [NUM_REGS];
  logic [NUM_CMDS-1:0] cmd_hit;

  assign in_cmds = {1'b0, addr} >= 9'(NUM_REGS) && {1'b0, addr} < 9'(NUM_REGS + NUM_CMDS);
  assign cmd_idx = addr - 8'(NUM_REGS);
  assign strobe_done = is_addr ? astb_sync[1] : dstb_sync[1];
  assign rd_sel = is_addr ? addr : addr == STATUS_ADDR ? status : rd_byte;
  // The host may only see our byte once the direction latched at cycle start says read
  assign EppDB = (is_rd && state != IDLE) ? dout : 8'hzz;

  always_comb begin
    cmd_hit = '0;
    rd_byte = 8'h00;
    status = 8'h00;
    for (int i = 0; i < NUM_CMDS; i++) begin
      if (in_cmds && cmd_idx == 8'(i)) begin
        cmd_hit[i] = 1'b1;
        rd_byte = {7'b0, busy[i]};
      end
    end
    for (int i = 0; i < 8 && i < NUM_CMDS; i++) status[i] = busy[i];
    for (int k = 0; k < NUM_REGS; k++) if (addr == 8'(k)) rd_byte = regs[k];
  end

  always_comb begin
    regs_flat = '0;
    for (int k = 0; k < NUM_REGS; k++) regs_flat[8*k +: 8] = regs[k];
  end

  always_comb begin
    state_next = state;
    state_next = state == IDLE ? ((!astb_sync[1] || !dstb_sync[1]) ? ACT : IDLE) :
                 state == ACT  ? ACK : (strobe_done ? IDLE : ACK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      astb_sync <= 2'b11;
      dstb_sync <= 2'b11;
      wr_sync <= 2'b00;
      state <= IDLE;
      is_addr <= 1'b0;
      is_rd <= 1'b0;
      addr <= 8'h00;
      dout <= 8'h00;
      EppWait <= 1'b0;
      cmd_strobe <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= 8'h00;
    end else begin
      astb_sync <= {astb_sync[0], EppAstb};
      dstb_sync <= {dstb_sync[0], EppDstb};
      wr_sync <= {wr_sync[0], EppWR};
      state <= state_next;
      cmd_strobe <= '0;
      if (state == IDLE && state_next == ACT) begin
        is_addr <= !astb_sync[1];
        is_rd <= wr_sync[1];
      end
      if (state == ACT) begin
        EppWait <= 1'b1;
        dout <= rd_sel;
        if (is_addr && !is_rd) addr <= EppDB;
`ifdef EPP_AUTOINC_EN
        if (!is_addr) addr <= addr + 8'd1;
`endif
        if (!is_addr && !is_rd) begin
          cmd_strobe <= cmd_hit;
          for (int k = 0; k < NUM_REGS; k++) if (addr == 8'(k)) regs[k] <= EppDB;
        end
      end
      if (state == ACK && strobe_done) EppWait <= 1'b0;
    end
  end
endmodule
